// File: rtl/reg_dst_pkg.sv
// Shared encodings and constants for the destination-register pipeline.
// Optional build macro used by this block: REG_DST_ZERO_SUPPRESS_EN.
package reg_dst_pkg;

    typedef enum logic [1:0] {
        SEL_RT  = 2'b00,
        SEL_R31 = 2'b01,
        SEL_RD  = 2'b10,
        SEL_ILL = 2'b11
    } sel_e;

    localparam int LINK_REG_DEF = 31;
    localparam int ZERO_REG     = 0;

    // A bubble is an entry that targets register 0 and never writes.
    localparam int   BUBBLE_DST = ZERO_REG;
    localparam logic BUBBLE_WR  = 1'b0;

endpackage

// File: rtl/reg_dst_sel.sv
// Combinational destination select (rt / link / rd) with illegal-select detect.
// With REG_DST_ZERO_SUPPRESS_EN defined, a selected destination of 0 never writes.
module reg_dst_sel
    import reg_dst_pkg::*;
#(
    parameter int NBITS    = 5,
    parameter int SELBITS  = 2,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic [NBITS-1:0]   i_reg_rt,
    input  logic [NBITS-1:0]   i_reg_rd,
    input  logic [SELBITS-1:0] i_sel,
    input  logic               i_wr,
    output logic [NBITS-1:0]   o_dst,
    output logic               o_wr,
    output logic               o_illegal
);

    logic [NBITS-1:0] w_dst;
    logic             w_wr;
    logic             w_known;

    always_comb begin
        w_dst   = NBITS'(ZERO_REG);
        w_wr    = 1'b0;
        w_known = 1'b1;
        if (i_sel == SELBITS'(SEL_RT)) begin
            w_dst = i_reg_rt;
            w_wr  = i_wr;
        end else if (i_sel == SELBITS'(SEL_R31)) begin
            w_dst = NBITS'(LINK_REG);
            w_wr  = i_wr;
        end else if (i_sel == SELBITS'(SEL_RD)) begin
            w_dst = i_reg_rd;
            w_wr  = i_wr;
        end else begin
            w_known = 1'b0;
        end
    end

    assign o_dst     = w_dst;
    assign o_illegal = !w_known && i_wr;

`ifdef REG_DST_ZERO_SUPPRESS_EN
    assign o_wr = w_wr && (w_dst != NBITS'(ZERO_REG));
`else
    assign o_wr = w_wr;
`endif

endmodule

// File: rtl/reg_dst_pipe.sv
// Destination-register selector carried with its write-enable through DEPTH stages,
// with stall/flush and per-stage address matching. Macro: REG_DST_ZERO_SUPPRESS_EN.
module reg_dst_pipe
    import reg_dst_pkg::*;
#(
    parameter int NBITS    = 5,
    parameter int SELBITS  = 2,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int DEPTH    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [NBITS-1:0]       reg_rt,
    input  logic [NBITS-1:0]       reg_rd,
    input  logic [SELBITS-1:0]     sel_reg,
    input  logic                   reg_write_in,
    input  logic [NBITS-1:0]       rs_addr,
    input  logic [NBITS-1:0]       rt_addr,
    output logic [DEPTH*NBITS-1:0] stage_dst,
    output logic [DEPTH-1:0]       stage_wr,
    output logic [NBITS-1:0]       wb_dst,
    output logic                   wb_wr,
    output logic [DEPTH-1:0]       match_rs,
    output logic [DEPTH-1:0]       match_rt,
    output logic [DEPTH-1:0]       fwd_rs_oh,
    output logic [DEPTH-1:0]       fwd_rt_oh,
    output logic                   sel_err
);

    logic [NBITS-1:0] r_dst [DEPTH];
    logic [DEPTH-1:0] r_wr;
    logic             r_sel_err;

    logic [NBITS-1:0] w_sel_dst;
    logic             w_sel_wr;
    logic             w_sel_ill;
    logic [DEPTH-1:0] w_hit_rs;
    logic [DEPTH-1:0] w_hit_rt;
    logic [DEPTH-1:0] w_match_rs;
    logic [DEPTH-1:0] w_match_rt;

    reg_dst_sel #(
        .NBITS    (NBITS),
        .SELBITS  (SELBITS),
        .LINK_REG (LINK_REG)
    ) u_sel (
        .i_reg_rt  (reg_rt),
        .i_reg_rd  (reg_rd),
        .i_sel     (sel_reg),
        .i_wr      (reg_write_in),
        .o_dst     (w_sel_dst),
        .o_wr      (w_sel_wr),
        .o_illegal (w_sel_ill)
    );

    // Stage 0 loads the selection when neither stall nor flush is high; flush turns
    // that load into a bubble even while stalled. Older stages move only when not stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dst[i] <= '0;
            end
            r_wr      <= '0;
            r_sel_err <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_dst[0] <= NBITS'(BUBBLE_DST);
                r_wr[0]  <= BUBBLE_WR;
            end else begin
                r_dst[0] <= w_sel_dst;
                r_wr[0]  <= w_sel_wr;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_dst[i] <= r_dst[i-1];
                r_wr[i]  <= r_wr[i-1];
            end
            r_sel_err <= !flush && w_sel_ill;
        end else if (flush) begin
            r_dst[0] <= NBITS'(BUBBLE_DST);
            r_wr[0]  <= BUBBLE_WR;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        assign stage_dst[g*NBITS +: NBITS] = r_dst[g];
        assign w_hit_rs[g] = r_wr[g] && (r_dst[g] == rs_addr);
        assign w_hit_rt[g] = r_wr[g] && (r_dst[g] == rt_addr);
    end

`ifdef REG_DST_ZERO_SUPPRESS_EN
    assign w_match_rs = (rs_addr != NBITS'(ZERO_REG)) ? w_hit_rs : '0;
    assign w_match_rt = (rt_addr != NBITS'(ZERO_REG)) ? w_hit_rt : '0;
`else
    assign w_match_rs = w_hit_rs;
    assign w_match_rt = w_hit_rt;
`endif

    assign stage_wr = r_wr;
    assign wb_dst   = r_dst[DEPTH-1];
    assign wb_wr    = r_wr[DEPTH-1];
    assign sel_err  = r_sel_err;
    assign match_rs = w_match_rs;
    assign match_rt = w_match_rt;

    // Two's-complement trick keeps only the lowest set bit: the youngest stage wins.
    assign fwd_rs_oh = w_match_rs & (~w_match_rs + DEPTH'(1));
    assign fwd_rt_oh = w_match_rt & (~w_match_rt + DEPTH'(1));

endmodule

// File: tb/tb_reg_dst_pipe.sv
// Bench for reg_dst_pipe: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_reg_dst_pipe;

    localparam int NBITS    = 5;
    localparam int SELBITS  = 2;
    localparam int LINK_REG = 31;
    localparam int DEPTH    = 3;
    localparam int W        = NBITS + 1;

    logic                   clk = 1'b0;
    logic                   reset, stall, flush;
    logic [NBITS-1:0]       reg_rt, reg_rd, rs_addr, rt_addr;
    logic [SELBITS-1:0]     sel_reg;
    logic                   reg_write_in;
    logic [DEPTH*NBITS-1:0] stage_dst;
    logic [DEPTH-1:0]       stage_wr, match_rs, match_rt, fwd_rs_oh, fwd_rt_oh;
    logic [NBITS-1:0]       wb_dst;
    logic                   wb_wr, sel_err;

    // clock / reset
    always #5 clk = ~clk;

    reg_dst_pipe #(
        .NBITS(NBITS), .SELBITS(SELBITS), .LINK_REG(LINK_REG), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .reg_rt(reg_rt), .reg_rd(reg_rd), .sel_reg(sel_reg),
        .reg_write_in(reg_write_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .stage_dst(stage_dst), .stage_wr(stage_wr), .wb_dst(wb_dst), .wb_wr(wb_wr),
        .match_rs(match_rs), .match_rt(match_rt),
        .fwd_rs_oh(fwd_rs_oh), .fwd_rt_oh(fwd_rt_oh), .sel_err(sel_err)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // scoreboard: exp_q[i] = {dst, wr} expected in stage i (index 0 = youngest)
    logic [W-1:0] exp_q[$];
    logic         exp_sel_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] spec_select(input logic [1:0] s, input logic [NBITS-1:0] rt,
                                                 input logic [NBITS-1:0] rd, input logic w);
        logic [NBITS-1:0] d;
        logic             e;
        case (s)
            2'b00:   begin d = rt;              e = w;    end
            2'b01:   begin d = NBITS'(LINK_REG); e = w;    end
            2'b10:   begin d = rd;              e = w;    end
            default: begin d = '0;              e = 1'b0; end
        endcase
`ifdef REG_DST_ZERO_SUPPRESS_EN
        if (d == '0) e = 1'b0;
`endif
        return {d, e};
    endfunction

    function automatic logic [DEPTH-1:0] model_match(input logic [NBITS-1:0] addr);
        logic [DEPTH-1:0] m;
        logic [W-1:0]     ent;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent = exp_q[i];
            if (ent[0] && ent[W-1:1] == addr) m[i] = 1'b1;
        end
`ifdef REG_DST_ZERO_SUPPRESS_EN
        if (addr == '0) m = '0;
`endif
        return m;
    endfunction

    function automatic logic [DEPTH-1:0] first_hit(input logic [DEPTH-1:0] m);
        logic [DEPTH-1:0] oh;
        oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i]) begin
                oh[i] = 1'b1;
                break;
            end
        end
        return oh;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
        exp_sel_err = 1'b0;
    end

    // behavioural model: the pipe as a queue of entries
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) exp_q[i] = '0;
            exp_sel_err = 1'b0;
        end else if (!stall) begin
            exp_q.push_front(flush ? W'(0) : spec_select(sel_reg, reg_rt, reg_rd, reg_write_in));
            void'(exp_q.pop_back());
            exp_sel_err = !flush && (sel_reg == 2'b11) && reg_write_in;
        end else if (flush) begin
            exp_q[0] = '0;
        end
    end

    // compare process
    logic [DEPTH*NBITS-1:0] e_dst;
    logic [DEPTH-1:0]       e_wr, e_mrs, e_mrt;
    logic [W-1:0]           e_ent;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_ent = exp_q[i];
                e_dst[i*NBITS +: NBITS] = e_ent[W-1:1];
                e_wr[i] = e_ent[0];
            end
            e_mrs = model_match(rs_addr);
            e_mrt = model_match(rt_addr);
            chk("cyc_stage_dst", stage_dst, e_dst);
            chk("cyc_stage_wr",  stage_wr,  e_wr);
            chk("cyc_wb_dst",    wb_dst,    e_dst[(DEPTH-1)*NBITS +: NBITS]);
            chk("cyc_wb_wr",     wb_wr,     e_wr[DEPTH-1]);
            chk("cyc_match_rs",  match_rs,  e_mrs);
            chk("cyc_match_rt",  match_rt,  e_mrt);
            chk("cyc_fwd_rs",    fwd_rs_oh, first_hit(e_mrs));
            chk("cyc_fwd_rt",    fwd_rt_oh, first_hit(e_mrt));
            chk("cyc_sel_err",   sel_err,   exp_sel_err);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [NBITS-1:0] rtv,
                         input logic [NBITS-1:0] rdv, input logic w);
        sel_reg      = s;
        reg_rt       = rtv;
        reg_rd       = rdv;
        reg_write_in = w;
    endtask

    function automatic logic [NBITS-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 9) return NBITS'(31);
        if (r == 8) return NBITS'($urandom_range(0, 31));
        return NBITS'(r);
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        rs_addr = '0; rt_addr = '0;
        drive(2'b00, '0, '0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_stage_dst", stage_dst, 0);
        chk("rst_stage_wr",  stage_wr,  0);
        chk("rst_sel_err",   sel_err,   0);
        chk("rst_match_rs",  match_rs,  0);

        // rd select, latency 1 to stage 0 and DEPTH to write-back
        drive(2'b10, '0, 5'd7, 1'b1);
        tick();
        chk("t1_s0_dst", stage_dst[NBITS-1:0], 7);
        chk("t1_s0_wr",  stage_wr[0], 1);
        tick(); tick();
        chk("t1_wb_dst", wb_dst, 7);
        chk("t1_wb_wr",  wb_wr, 1);

        // link select, then illegal select
        drive(2'b01, '0, '0, 1'b1);
        tick(); tick(); tick();
        chk("t2_wb_link", wb_dst, 31);
        chk("t2_wb_wr",   wb_wr, 1);
        drive(2'b11, 5'd4, 5'd4, 1'b1);
        tick();
        chk("t2_ill_dst", stage_dst[NBITS-1:0], 0);
        chk("t2_ill_wr",  stage_wr[0], 0);
        chk("t2_sel_err", sel_err, 1);
        drive(2'b10, '0, 5'd4, 1'b1);
        tick();
        chk("t2_sel_err_clr", sel_err, 0);

        // 5,6,7 then stall two cycles with flush on the first
        drive(2'b10, '0, 5'd5, 1'b1); tick();
        drive(2'b10, '0, 5'd6, 1'b1); tick();
        drive(2'b10, '0, 5'd7, 1'b1); tick();
        chk("t3_wb_5", wb_dst, 5);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("t3_flush_dst", stage_dst, {5'd5, 5'd6, 5'd0});
        chk("t3_flush_wr",  stage_wr, 3'b110);
        flush = 1'b0;
        tick();
        chk("t3_hold_dst", stage_dst, {5'd5, 5'd6, 5'd0});
        stall = 1'b0;
        drive(2'b11, '0, '0, 1'b0);
        tick();
        chk("t3_wb_6",    wb_dst, 6);
        chk("t3_wb_6_wr", wb_wr, 1);
        tick();
        chk("t3_wb_bub",    wb_dst, 0);
        chk("t3_wb_bub_wr", wb_wr, 0);

        // stages {3,3,9}
        drive(2'b10, '0, 5'd9, 1'b1); tick();
        drive(2'b10, '0, 5'd3, 1'b1); tick();
        tick();
        rs_addr = 5'd3; rt_addr = 5'd9;
        #1;
        chk("t4_match_rs", match_rs, 3'b011);
        chk("t4_fwd_rs",   fwd_rs_oh, 3'b001);
        chk("t4_match_rt", match_rt, 3'b100);
        chk("t4_fwd_rt",   fwd_rt_oh, 3'b100);

        // writes to register 0
        drive(2'b00, 5'd0, 5'd12, 1'b1);
        rs_addr = 5'd0;
        tick();
`ifdef REG_DST_ZERO_SUPPRESS_EN
        chk("t5_zero_wr",    stage_wr[0], 0);
        chk("t5_zero_match", match_rs, 0);
`else
        chk("t5_zero_wr",    stage_wr[0], 1);
        chk("t5_zero_match", match_rs, 3'b001);
`endif

        // reset with stall over a full pipe
        drive(2'b10, '0, 5'd10, 1'b1); tick();
        drive(2'b10, '0, 5'd11, 1'b1); tick();
        drive(2'b10, '0, 5'd12, 1'b1); tick();
        chk("t6_full_wr", stage_wr, 3'b111);
        rs_addr = 5'd12;
        reset = 1'b1; stall = 1'b1;
        tick();
        chk("t6_rst_dst",   stage_dst, 0);
        chk("t6_rst_wr",    stage_wr, 0);
        chk("t6_rst_match", match_rs, 0);
        chk("t6_rst_err",   sel_err, 0);
        reset = 1'b0; stall = 1'b0;
        drive(2'b10, '0, 5'd13, 1'b1);
        tick();
        chk("t6_resume_s0", stage_dst[NBITS-1:0], 13);
        tick(); tick();
        chk("t6_resume_wb", wb_dst, 13);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 15);
            drive(2'($urandom_range(0, 3)), pick_addr(), pick_addr(), 1'($urandom_range(0, 1)));
            rs_addr = pick_addr();
            rt_addr = pick_addr();
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
